// File: rtl/pwm_dimmer_ctrl_if.sv
// Signal bundle between an upstream period counter / control source and
// the PWM dimmer. The master drives count and requests; the slave (the
// dimmer) drives the LED and status outputs.
interface pwm_dimmer_ctrl_if;
  logic [3:0] count_in;
  logic       step_up;
  logic       step_down;
  logic       fade_en;
  logic       pwm_out;
  logic [3:0] duty_active;
  logic [3:0] duty_pending;
  logic       period_tick;
  logic [1:0] fade_state;

  modport master (
    output count_in, step_up, step_down, fade_en,
    input  pwm_out, duty_active, duty_pending, period_tick, fade_state
  );

  modport slave (
    input  count_in, step_up, step_down, fade_en,
    output pwm_out, duty_active, duty_pending, period_tick, fade_state
  );
endinterface

// File: rtl/pwm_dimmer_ctrl.sv
// PWM LED dimmer driven by an external free-running 4-bit period counter.
// Duty changes (manual steps or automatic triangular fade) are staged in
// duty_pending and only take effect at the 15->0 period boundary, so a
// PWM period is never cut short or stretched mid-way.
module pwm_dimmer_ctrl #(
  parameter int unsigned FADE_PERIODS = 4
) (
  input  logic clk,
  input  logic reset,
  pwm_dimmer_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    FADE_UP   = 2'b01,
    FADE_DOWN = 2'b10
  } state_t;

  localparam logic [7:0] FADE_LIMIT = 8'(FADE_PERIODS);

  state_t     state_q, state_d;
  logic [3:0] count_q;
  logic [3:0] duty_active_q;
  logic [3:0] duty_pending_q, duty_pending_d;
  logic [7:0] fade_cnt_q, fade_cnt_d;
  logic [7:0] fade_cnt_inc;
  logic [3:0] next_duty;
  logic       wrap;
  logic       pwm_q;
  logic       tick_q;

  // A boundary is a real 15->0 step of the upstream counter; a counter
  // held at 15 (or the reset value of count_q) never qualifies.
  assign wrap      = (count_q == 4'd15) && (bus.count_in == 4'd0);
  // The compare in the wrap cycle must already use the new duty so the
  // first cycle of a period matches the rest of it.
  assign next_duty = wrap ? duty_pending_q : duty_active_q;
  assign fade_cnt_inc = fade_cnt_q + 8'd1;

  // Period tracking, active duty and registered LED drive.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q       <= '0;
      duty_active_q <= '0;
      pwm_q         <= 1'b0;
      tick_q        <= 1'b0;
    end else begin
      count_q       <= bus.count_in;
      duty_active_q <= next_duty;
      pwm_q         <= (bus.count_in < next_duty);
      tick_q        <= wrap;
    end
  end

  // Fade FSM state, fade period counter and staged duty.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      fade_cnt_q     <= '0;
      duty_pending_q <= '0;
    end else begin
      state_q        <= state_d;
      fade_cnt_q     <= fade_cnt_d;
      duty_pending_q <= duty_pending_d;
    end
  end

  // Next state: manual steps in IDLE, one fade step every FADE_PERIODS
  // boundaries while fading, reversing at the 0/15 rails.
  always_comb begin
    state_d        = state_q;
    fade_cnt_d     = fade_cnt_q;
    duty_pending_d = duty_pending_q;
    case (state_q)
      IDLE: begin
        fade_cnt_d = '0;
        if (bus.step_up && !bus.step_down && duty_pending_q != 4'd15)
          duty_pending_d = duty_pending_q + 4'd1;
        else if (bus.step_down && !bus.step_up && duty_pending_q != 4'd0)
          duty_pending_d = duty_pending_q - 4'd1;
        if (bus.fade_en)
          state_d = FADE_UP;
      end
      FADE_UP: begin
        if (!bus.fade_en) begin
          state_d    = IDLE;
          fade_cnt_d = '0;
        end else if (wrap) begin
          if (fade_cnt_inc == FADE_LIMIT) begin
            fade_cnt_d = '0;
            // Already at the top rail: turn around instead of overflowing.
            if (duty_pending_q == 4'd15) begin
              duty_pending_d = duty_pending_q - 4'd1;
              state_d        = FADE_DOWN;
            end else begin
              duty_pending_d = duty_pending_q + 4'd1;
              if (duty_pending_q == 4'd14)
                state_d = FADE_DOWN;
            end
          end else begin
            fade_cnt_d = fade_cnt_inc;
          end
        end
      end
      FADE_DOWN: begin
        if (!bus.fade_en) begin
          state_d    = IDLE;
          fade_cnt_d = '0;
        end else if (wrap) begin
          if (fade_cnt_inc == FADE_LIMIT) begin
            fade_cnt_d = '0;
            if (duty_pending_q == 4'd0) begin
              duty_pending_d = duty_pending_q + 4'd1;
              state_d        = FADE_UP;
            end else begin
              duty_pending_d = duty_pending_q - 4'd1;
              if (duty_pending_q == 4'd1)
                state_d = FADE_UP;
            end
          end else begin
            fade_cnt_d = fade_cnt_inc;
          end
        end
      end
      default: begin
        state_d    = IDLE;
        fade_cnt_d = '0;
      end
    endcase
  end

  assign bus.pwm_out      = pwm_q;
  assign bus.duty_active  = duty_active_q;
  assign bus.duty_pending = duty_pending_q;
  assign bus.period_tick  = tick_q;
  assign bus.fade_state   = state_q;

endmodule

// File: tb/tb_pwm_dimmer_ctrl.sv
// Bench for pwm_dimmer_ctrl: stimulus process drives inputs on the falling
// edge, advances a behavioural model and queues the expected post-edge
// outputs; a monitor process compares after every rising edge.
module tb_pwm_dimmer_ctrl;

  localparam int FP = 4;

  logic clk;
  logic reset;
  pwm_dimmer_ctrl_if bus ();

  pwm_dimmer_ctrl #(.FADE_PERIODS(FP)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int pwm;
    int da;
    int dp;
    int tick;
    int st;
  } exp_t;

  exp_t q[$];
  int checks   = 0;
  int failures = 0;

  // Reference model: brightness levels and a fade direction as integers.
  int m_prev, m_da, m_dp, m_st, m_fcnt;
  int cnt;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_prev = 0; m_da = 0; m_dp = 0; m_st = 0; m_fcnt = 0;
  endtask

  // One clock of the specified behaviour, given this cycle's inputs.
  function automatic exp_t model_step(input int c, input bit up, input bit dn, input bit fen);
    exp_t e;
    int wrap, applied, dir, nd;
    wrap    = (m_prev == 15 && c == 0) ? 1 : 0;
    applied = wrap ? m_dp : m_da;
    e.pwm   = (c < applied) ? 1 : 0;
    e.tick  = wrap;
    if (wrap) m_da = m_dp;
    if (m_st == 0) begin
      if (up && !dn) m_dp = (m_dp < 15) ? m_dp + 1 : 15;
      else if (dn && !up) m_dp = (m_dp > 0) ? m_dp - 1 : 0;
      m_fcnt = 0;
      if (fen) m_st = 1;
    end else if (!fen) begin
      m_st = 0;
      m_fcnt = 0;
    end else if (wrap) begin
      m_fcnt++;
      if (m_fcnt == FP) begin
        m_fcnt = 0;
        dir = (m_st == 1) ? 1 : -1;
        nd  = m_dp + dir;
        if (nd > 15 || nd < 0) begin
          dir = -dir;
          nd  = m_dp + dir;
        end
        m_dp = nd;
        if (nd == 15) m_st = 2;
        else if (nd == 0) m_st = 1;
        else m_st = (dir > 0) ? 1 : 2;
      end
    end
    m_prev = c;
    e.da = m_da;
    e.dp = m_dp;
    e.st = m_st;
    return e;
  endfunction

  task automatic drive(input int c, input bit up, input bit dn, input bit fen);
    exp_t e;
    @(negedge clk);
    bus.count_in  = 4'(c);
    bus.step_up   = up;
    bus.step_down = dn;
    bus.fade_en   = fen;
    e = model_step(c, up, dn, fen);
    q.push_back(e);
  endtask

  task automatic adv(input bit up, input bit dn, input bit fen);
    cnt = (cnt + 1) % 16;
    drive(cnt, up, dn, fen);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_pwm"},   int'(bus.pwm_out), 0);
    chk({tag, "_da"},    int'(bus.duty_active), 0);
    chk({tag, "_dp"},    int'(bus.duty_pending), 0);
    chk({tag, "_tick"},  int'(bus.period_tick), 0);
    chk({tag, "_state"}, int'(bus.fade_state), 0);
  endtask

  // Reset asserted between edges; outputs must clear without a clock.
  task automatic mid_reset(input string tag);
    @(negedge clk);
    #1 reset = 1'b1;
    #1 check_zero(tag);
    @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
  endtask

  // Monitor: compare DUT against the queued expectation after each edge.
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("pwm_out",      int'(bus.pwm_out),      e.pwm);
      chk("duty_active",  int'(bus.duty_active),  e.da);
      chk("duty_pending", int'(bus.duty_pending), e.dp);
      chk("period_tick",  int'(bus.period_tick),  e.tick);
      chk("fade_state",   int'(bus.fade_state),   e.st);
    end
  end

  task automatic fade_until(input int dp, input int st, input string tag);
    int n;
    n = 0;
    while (!(m_dp == dp && (st < 0 || m_st == st)) && n < 3000) begin
      adv(1'b0, 1'b0, 1'b1);
      n++;
    end
    chk({tag, "_budget"}, (n < 3000) ? 1 : 0, 1);
  endtask

  initial begin
    int n, highs;
    bit fen_r;
    reset         = 1'b1;
    bus.count_in  = '0;
    bus.step_up   = 1'b0;
    bus.step_down = 1'b0;
    bus.fade_en   = 1'b0;
    cnt = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #2 check_zero("reset");
    @(negedge clk);
    reset = 1'b0;

    // Three steps up, then observe one full period at duty 3.
    repeat (3) adv(1'b1, 1'b0, 1'b0);
    settle();
    chk("step3_pending", int'(bus.duty_pending), 3);
    n = 0;
    while (bus.duty_active != 4'd3 && n < 40) begin
      adv(1'b0, 1'b0, 1'b0);
      settle();
      n++;
    end
    chk("step3_active", int'(bus.duty_active), 3);
    highs = 0;
    repeat (16) begin
      adv(1'b0, 1'b0, 1'b0);
      settle();
      highs += int'(bus.pwm_out);
    end
    chk("pwm_highs_3", highs, 3);

    // Saturation at both rails and simultaneous requests.
    repeat (16) adv(1'b1, 1'b0, 1'b0);
    adv(1'b1, 1'b0, 1'b0);
    settle();
    chk("sat_hi", int'(bus.duty_pending), 15);
    repeat (16) adv(1'b0, 1'b1, 1'b0);
    adv(1'b0, 1'b1, 1'b0);
    settle();
    chk("sat_lo", int'(bus.duty_pending), 0);
    repeat (7) adv(1'b1, 1'b0, 1'b0);
    adv(1'b1, 1'b1, 1'b0);
    settle();
    chk("both_7", int'(bus.duty_pending), 7);

    // Upstream counter stalled at 15: no boundary until 15->0 happens.
    while (cnt != 15) adv(1'b0, 1'b0, 1'b0);
    repeat (10) drive(cnt, 1'b0, 1'b0, 1'b0);
    repeat (20) adv(1'b0, 1'b0, 1'b0);

    // Fade: start at 0, climb to 15, fall back to 0.
    repeat (16) adv(1'b0, 1'b1, 1'b0);
    fade_until(15, 2, "fade_top");
    settle();
    chk("fade_top_state", int'(bus.fade_state), 2);
    chk("fade_top_dp",    int'(bus.duty_pending), 15);
    fade_until(0, 1, "fade_bot");
    settle();
    chk("fade_bot_state", int'(bus.fade_state), 1);
    chk("fade_bot_dp",    int'(bus.duty_pending), 0);

    // Leave fade at 9; value held and manual steps resume.
    fade_until(9, -1, "fade_9");
    adv(1'b0, 1'b0, 1'b0);
    settle();
    chk("exit_state", int'(bus.fade_state), 0);
    chk("exit_dp",    int'(bus.duty_pending), 9);
    adv(1'b1, 1'b0, 1'b0);
    settle();
    chk("exit_step", int'(bus.duty_pending), 10);

    // Reset mid-fade at duty 6, then a first count of 0 must not wrap.
    fade_until(15, 2, "fade_top2");
    fade_until(6, 2, "fade_6");
    mid_reset("midreset");
    cnt = 15;
    repeat (20) adv(1'b0, 1'b0, 1'b0);

    // Randomised traffic with stalls, fade toggling and occasional resets.
    fen_r = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) fen_r = ~fen_r;
      if ($urandom_range(0, 999) == 0) mid_reset("rnd_reset");
      if ($urandom_range(0, 7) == 0)
        drive(cnt, ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), fen_r);
      else
        adv(($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), fen_r);
    end

    repeat (3) @(posedge clk);
    #2 chk("queue_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pwm_dimmer_ctrl.md
PWM_DIMMER_CTRL -- requirements
Module: pwm_dimmer_ctrl

Interface
REQ-001 Parameter FADE_PERIODS, default 4, meaning number of PWM periods per fade step (legal range 1..255).
REQ-002 clk  input  1  single system clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 count_in  input  4  free-running period count from the upstream 4-bit counter, 0..15.
REQ-005 step_up  input  1  single-cycle request to raise brightness by one step.
REQ-006 step_down  input  1  single-cycle request to lower brightness by one step.
REQ-007 fade_en  input  1  level; high selects automatic triangular fade.
REQ-008 pwm_out  output  1  registered LED drive.
REQ-009 duty_active  output  4  duty value applied to the current PWM period.
REQ-010 duty_pending  output  4  duty value to be applied at the next period boundary.
REQ-011 period_tick  output  1  one-cycle pulse after each period boundary.
REQ-012 fade_state  output  2  FSM state: 00 IDLE, 01 FADE_UP, 10 FADE_DOWN.

Function
REQ-013 Block SHALL register count_in into count_q every cycle.
REQ-014 wrap SHALL be true in a cycle where count_q == 15 and count_in == 0; a held count_in (upstream enable low) SHALL NOT produce wrap.
REQ-015 period_tick SHALL be high exactly in the cycle following a wrap cycle, low otherwise.
REQ-016 next_duty SHALL equal duty_pending when wrap is true, else duty_active; duty_active SHALL load duty_pending on every wrap edge, and SHALL never change at any other time.
REQ-017 pwm_out SHALL be registered as (count_in < next_duty), unsigned 4-bit compare; latency 1 cycle from count_in.
REQ-018 Duty 0 SHALL give pwm_out constantly low; duty N SHALL give N high cycles per 16-cycle period; duty 15 gives 15/16.
REQ-019 In IDLE, step_up alone SHALL increment duty_pending, saturating at 15; step_down alone SHALL decrement, saturating at 0.
REQ-020 step_up and step_down asserted in the same cycle SHALL leave duty_pending unchanged.
REQ-021 Step requests SHALL be ignored in FADE_UP and FADE_DOWN.
REQ-022 FSM: IDLE -> FADE_UP when fade_en high; any state -> IDLE when fade_en low (next edge); duty_pending SHALL hold its value on leaving fade.
REQ-023 A fade period counter (8-bit) SHALL increment on each wrap while fading, clear in IDLE, and on reaching FADE_PERIODS SHALL clear and issue one fade step in that same wrap cycle.
REQ-024 Fade step in FADE_UP: duty_pending +1; if result is 15 state SHALL become FADE_DOWN. In FADE_DOWN: duty_pending -1; if result is 0 state SHALL become FADE_UP.
REQ-025 Entering FADE_UP with duty_pending == 15 SHALL transition to FADE_DOWN on the first fade step without incrementing (decrement instead); no wrap beyond 0..15 SHALL ever occur.
REQ-026 A fade step and the duty_active load in the same wrap edge SHALL load the pre-step duty_pending value; the stepped value applies the following period.

Reset
REQ-027 On reset assertion, asynchronously: pwm_out 0, duty_active 0, duty_pending 0, period_tick 0, fade_state IDLE, count_q 0, fade counter 0.
REQ-028 Because count_q resets to 0, the first count_in == 0 after reset SHALL NOT be treated as a wrap.
REQ-029 Reset asserted mid-fade or mid-period SHALL abort immediately; after release the block SHALL resume from IDLE with duty 0.

Verification
REQ-030 Reset, 3x step_up, free-running count -> duty_pending 3 at once, duty_active 3 after next 15->0 wrap, pwm_out high 3 of 16 cycles.
REQ-031 duty_pending 15, step_up -> stays 15; duty_pending 0, step_down -> stays 0; step_up+step_down same cycle from 7 -> stays 7.
REQ-032 Upstream counter held at 15 for 10 cycles then advancing -> no wrap, no period_tick until 15->0 actually occurs.
REQ-033 fade_en high, FADE_PERIODS 4, start duty 0 -> duty_pending +1 every 4 wraps, reaches 15, state FADE_DOWN, returns to 0, state FADE_UP.
REQ-034 fade_en dropped at duty_pending 9 -> IDLE next cycle, duty 9 held, step_up then accepted -> 10.
REQ-035 Reset asserted mid-fade at duty 6 -> all outputs zero/IDLE same cycle without clock edge; no wrap on first count 0 after release.
